// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE_S = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Smallest width that holds 10^ndig - 1: 4/7/10/14 for ndig 1/2/3/4.
  function automatic int bcd_bin_width(input int ndig);
    int p;
    int w;
    p = 1;
    for (int i = 0; i < ndig; i++) begin
      p = p * 10;
    end
    w = 0;
    while ((64'd1 << w) < 64'(p)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_sub3_cell.sv
// Per-digit correction for reverse double-dabble: a digit of 8 or more loses 3.
module bcd_sub3_cell (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= 4'd8) ? (in_i - 4'd3) : in_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one bit per clock with START/BUSY/DONE handshake.
// Optional macro BCD_CHECK_EN: reject operands with a digit above 9 (ERR=1, BIN=0, no SHIFT).
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG = 2
) (
  input  logic                            clk,
  input  logic                            CLR,
  input  logic                            START,
  input  logic [4*NDIG-1:0]               D,
  output logic [bcd_bin_width(NDIG)-1:0]  BIN,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            ERR
);

  localparam int BW = bcd_bin_width(NDIG);
  localparam int CW = $clog2(BW + 1);
  localparam int WW = 4 * NDIG + BW;

  state_e          state_q;
  logic [WW-1:0]   work_q;
  logic [WW-1:0]   work_sh_s;
  logic [WW-1:0]   work_d;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   bin_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            d_bad_s;

  assign work_sh_s = work_q >> 1;
  assign work_d[BW-1:0] = work_sh_s[BW-1:0];

  // One correction cell per BCD digit, applied after the shift.
  for (genvar g = 0; g < NDIG; g++) begin : g_cell
    bcd_sub3_cell u_cell (
      .in_i  (work_sh_s[BW+4*g +: 4]),
      .out_o (work_d[BW+4*g +: 4])
    );
  end

`ifdef BCD_CHECK_EN
  // Flags any operand digit outside 0..9.
  always_comb begin
    d_bad_s = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      d_bad_s = d_bad_s | (D[4*i +: 4] > BCD_MAX);
    end
  end
`else
  assign d_bad_s = 1'b0;
`endif

  // Controller, counter, work register and registered outputs.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE_S: begin
          if (START) begin
            work_q <= {D, {BW{1'b0}}};
            cnt_q  <= '0;
            if (d_bad_s) begin
              // Invalid operand: skip conversion and report straight away.
              err_q   <= 1'b1;
              bin_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE_S;
            end else begin
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              state_q <= SHIFT;
            end
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(BW - 1)) begin
            bin_q   <= work_d[BW-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE_S;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign BIN  = bin_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
`ifdef BCD_CHECK_EN
  assign ERR  = err_q;
`else
  assign ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq (NDIG=2): directed operands, monitor checks result, ERR, latency, BUSY length.
module tb_bcd_to_bin_seq;

  logic       clk;
  logic       CLR;
  logic       START;
  logic [7:0] D;
  logic [6:0] BIN;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int bcnt     = 0;

  typedef struct {
    logic [6:0] bin;
    logic       err;
    logic       chk_bin;
    int         lat;
    int         busy;
    int         acc;
  } exp_t;

  exp_t sb[$];

  bcd_to_bin_seq #(.NDIG(2)) dut (
    .clk   (clk),
    .CLR   (CLR),
    .START (START),
    .D     (D),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per DONE pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!CLR) begin
      bcnt = 0;
    end else begin
      if (DONE) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.chk_bin) check("bin", int'(BIN), int'(e.bin));
          check("err", int'(ERR), int'(e.err));
          check("latency", cyc - e.acc, e.lat);
          check("busy_cycles", bcnt, e.busy);
        end
        bcnt = 0;
      end
      if (BUSY) bcnt++;
    end
  end

  task automatic conv(input logic [7:0] d, input logic [6:0] b, input logic e,
                      input logic chk, input int lat, input int busy);
    exp_t x;
    @(negedge clk);
    D = d;
    START = 1'b1;
    x.bin = b; x.err = e; x.chk_bin = chk; x.lat = lat; x.busy = busy; x.acc = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    START = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  logic [7:0] vec_d [4] = '{8'h10, 8'h09, 8'h90, 8'h57};
  logic [6:0] vec_b [4] = '{7'd10, 7'd9, 7'd90, 7'd57};

  initial begin
    exp_t x;
    int   k;
    CLR = 1'b0; START = 1'b0; D = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_bin", int'(BIN), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_err", int'(ERR), 0);
    CLR = 1'b1;
    @(negedge clk);

    conv(8'h99, 7'd99, 1'b0, 1'b1, 7, 7);
    drain();

    for (int i = 0; i < 4; i++) begin
      conv(vec_d[i], vec_b[i], 1'b0, 1'b1, 7, 7);
      drain();
    end

    // Back-to-back: START held through DONE_S.
    @(negedge clk);
    D = 8'h42; START = 1'b1;
    k = cyc + 1;
    x.bin = 7'd42; x.err = 1'b0; x.chk_bin = 1'b1; x.lat = 7; x.busy = 7; x.acc = k;
    sb.push_back(x);
    @(negedge clk);
    D = 8'h00;
    x.bin = 7'd0; x.acc = k + 8;
    sb.push_back(x);
    repeat (7) @(negedge clk);
    @(negedge clk);
    START = 1'b0;
    drain();

    // START during SHIFT is ignored; D changes after capture do not matter.
    conv(8'h37, 7'd37, 1'b0, 1'b1, 7, 7);
    repeat (2) @(negedge clk);
    D = 8'h11; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    check("bin_hold", int'(BIN), 37);

    // Abort mid-conversion.
    conv(8'h25, 7'd25, 1'b0, 1'b1, 7, 7);
    sb.delete();
    repeat (3) @(negedge clk);
    CLR = 1'b0;
    #1;
    check("abort_busy", int'(BUSY), 0);
    check("abort_done", int'(DONE), 0);
    check("abort_bin", int'(BIN), 0);
    repeat (2) @(negedge clk);
    CLR = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_bin_idle", int'(BIN), 0);
    conv(8'h58, 7'd58, 1'b0, 1'b1, 7, 7);
    drain();

`ifdef BCD_CHECK_EN
    conv(8'hA5, 7'd0, 1'b1, 1'b1, 0, 0);
`else
    conv(8'hA5, 7'd0, 1'b0, 1'b0, 7, 7);
`endif
    drain();

    conv(8'h63, 7'd63, 1'b0, 1'b1, 7, 7);
    drain();

    repeat (10) @(negedge clk);
    check("final_queue", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
